mcdatapath_p: RTL and testbench
===============================

MCDATAPATH_P -- requirements
Module: mcdatapath_p

Interface
REQ-001 Parameters SHALL be: W, 16, datapath width; NREG, 8, register count (power of two, >=4); RA, log2(NREG), register-address width; IMMB, 6, branch-immediate width; IMMJ, 9, jump-immediate width; RESET_PC, 0, PC value after reset.
REQ-002 Ports SHALL be: clk input 1 clock; reset input 1 asynchronous active-low reset.
REQ-003 Control inputs SHALL be: pcen 1; irwrite 1; regwrite 1; flagwrite 1; alusrca 1; iord 1; memtoreg 1; regdst 1; memstart 1 (begin memory access); memwe 1 (access is a write); alusrcb 2; pcsrc 2; alucontrol 3.
REQ-004 Status outputs SHALL be: op output 4 instr[15:12]; compare output 1 srca==srcb; busy output 1 memory access in progress; memdone output 1 one-cycle completion pulse.
REQ-005 Memory ports SHALL be: mem_req output 1; mem_we output 1; mem_adr output W; mem_wdata output W; mem_rdata input W; mem_ack input 1.
REQ-006 Debug outputs SHALL be: pc output W; cflag output 1; zflag output 1; regs output NREG*W, register i at bits [i*W +: W].

Function
REQ-007 Memory FSM states SHALL be IDLE, BUSY, DONE; IDLE->BUSY on memstart; BUSY->DONE on mem_ack; DONE->IDLE unconditionally.
REQ-008 In BUSY, mem_req SHALL be 1 and mem_adr (iord ? aluout : pc), mem_we, mem_wdata (B register) SHALL be frozen at the values latched on entry.
REQ-009 On the mem_ack cycle, mem_rdata SHALL be captured into the data register and, if irwrite is 1, into the instruction register; busy SHALL fall and memdone SHALL be 1 in the following DONE cycle.
REQ-010 memstart in BUSY or DONE SHALL be ignored; mem_ack in IDLE or DONE SHALL be ignored; mem_ack in the same cycle as entry to BUSY SHALL not complete the access.
REQ-011 While busy=1, pcen, regwrite, flagwrite and irwrite SHALL have no effect; A, B and aluout registers SHALL hold.
REQ-012 ALU SHALL implement alucontrol 000 add, 001 sub, 010 nand, 011 and, 100 or, 101 xor, 110 srca shl 1, 111 pass srcb; all W bits wide.
REQ-013 ALU carry SHALL be bit W of the (W+1)-bit add/sub result (sub carry = no borrow), 0 for other ops; zero SHALL be 1 when result==0.
REQ-014 Flags cflag/zflag SHALL load ALU carry/zero on the clock edge where flagwrite=1 and busy=0.
REQ-015 Register write SHALL occur when regwrite=1, busy=0 and condition instr[1:0] holds: 00 or 11 always, 10 only if cflag=1, 01 only if zflag=1; condition is bypassed when pcsrc[1]=1.
REQ-016 Write address SHALL be regdst ? instr[5:3] : instr[8:6] (low RA bits), forced to NREG-1 when pcsrc[1]=1; write data SHALL be memtoreg ? data : aluout, replaced by aluresult when pcsrc[1]=1.
REQ-017 Register reads SHALL be combinational on instr[11:9] and instr[8:6]; a same-cycle write SHALL not be visible until the next cycle.
REQ-018 srca SHALL be alusrca ? A : pc; srcb SHALL be by alusrcb 00 B, 01 constant 2, 10 signimm, 11 signimm shl 1.
REQ-019 signimm SHALL be sign-extended instr[IMMB-1:0] when pcsrc[1]=0, else sign-extended instr[IMMJ-1:0].
REQ-020 Next PC SHALL be by pcsrc 00 aluresult, 01 aluout, 10 aluout, 11 A (jump-register), loaded when pcen=1 and busy=0; arithmetic wraps modulo 2^W.

Reset
REQ-021 reset=0 SHALL asynchronously set pc=RESET_PC, FSM=IDLE, mem_req=0, mem_we=0, busy=0, memdone=0, flags=0, and instr, data, A, B, aluout and all registers to 0.
REQ-022 Reset during BUSY SHALL abort the access with mem_req=0 in the same cycle; a late mem_ack SHALL be ignored.

Structure
REQ-023 A shared package SHALL hold ALU op codes, pcsrc codes, condition codes and the FSM state enumeration.
REQ-024 The register file SHALL be a separate sub-module regfile_p, parametrised by W and NREG.

Verification
REQ-025 Reset release -> pc=0x0000, regs all 0, mem_req=0, busy=0.
REQ-026 Fetch, mem_ack after 3 wait cycles, mem_rdata=0x1234, irwrite=1 -> mem_req high 3 cycles, op=0x1, memdone one pulse, pc unchanged until pcen with busy=0.
REQ-027 r1=0xFFFF, r2=0x0001, add, flagwrite -> aluresult 0x0000, cflag=1, zflag=1; next instr[1:0]=10 writes, instr[1:0]=01 with zflag=0 does not write.
REQ-028 pcsrc=10, pc=0x0010, imm9=0x1FF -> r7=pc link value, pc=0x000E.
REQ-029 memstart while busy, and pcen asserted during BUSY -> no second access, pc holds.
REQ-030 W=32, NREG=16 build, reset asserted mid-BUSY then mem_ack -> mem_req=0 immediately, no data capture.

Source files
------------

// File: rtl/mcdatapath_p_pkg.sv
// Shared encodings for the multicycle datapath: ALU ops, PC source, write
// conditions and the memory handshake FSM states.
package mcdatapath_p_pkg;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SUB  = 3'b001,
        ALU_NAND = 3'b010,
        ALU_AND  = 3'b011,
        ALU_OR   = 3'b100,
        ALU_XOR  = 3'b101,
        ALU_SHL  = 3'b110,
        ALU_PASS = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        PC_ALU    = 2'b00,
        PC_ALUOUT = 2'b01,
        PC_JMP    = 2'b10,
        PC_JR     = 2'b11
    } pcsrc_e;

    typedef enum logic [1:0] {
        COND_AL  = 2'b00,
        COND_Z   = 2'b01,
        COND_C   = 2'b10,
        COND_AL2 = 2'b11
    } cond_e;

    typedef enum logic [1:0] {
        M_IDLE = 2'b00,
        M_BUSY = 2'b01,
        M_DONE = 2'b10
    } mstate_e;

endpackage

// File: rtl/mcdatapath_p_regfile.sv
// Register file: two combinational read ports, one synchronous write port,
// and a flat debug view of every register.
module regfile_p #(
    parameter int W    = 16,
    parameter int NREG = 8,
    parameter int RA   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we,
    input  logic [RA-1:0]   wa,
    input  logic [W-1:0]    wd,
    input  logic [RA-1:0]   ra1,
    input  logic [RA-1:0]   ra2,
    output logic [W-1:0]    rd1,
    output logic [W-1:0]    rd2,
    output logic [NREG*W-1:0] regs
);

    logic [W-1:0] rf [NREG];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else if (we) begin
            for (int i = 0; i < NREG; i++)
                if (wa == RA'(i)) rf[i] <= wd;
        end
    end

    // Reads see the old value during a write cycle.
    assign rd1 = rf[ra1];
    assign rd2 = rf[ra2];

    for (genvar i = 0; i < NREG; i++) begin : g_view
        assign regs[i*W +: W] = rf[i];
    end

endmodule

// File: rtl/mcdatapath_p.sv
// Multicycle datapath: ALU, PC, flags, instruction/data registers and a
// handshaked memory port that stalls architectural state while busy.
module mcdatapath_p
    import mcdatapath_p_pkg::*;
#(
    parameter int          W        = 16,
    parameter int          NREG     = 8,
    parameter int          RA       = $clog2(NREG),
    parameter int          IMMB     = 6,
    parameter int          IMMJ     = 9,
    parameter logic [W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pcen,
    input  logic              irwrite,
    input  logic              regwrite,
    input  logic              flagwrite,
    input  logic              alusrca,
    input  logic              iord,
    input  logic              memtoreg,
    input  logic              regdst,
    input  logic              memstart,
    input  logic              memwe,
    input  logic [1:0]        alusrcb,
    input  logic [1:0]        pcsrc,
    input  logic [2:0]        alucontrol,
    output logic [3:0]        op,
    output logic              compare,
    output logic              busy,
    output logic              memdone,
    output logic              mem_req,
    output logic              mem_we,
    output logic [W-1:0]      mem_adr,
    output logic [W-1:0]      mem_wdata,
    input  logic [W-1:0]      mem_rdata,
    input  logic              mem_ack,
    output logic [W-1:0]      pc,
    output logic              cflag,
    output logic              zflag,
    output logic [NREG*W-1:0] regs
);

    mstate_e      state, state_n;
    logic [W-1:0] instr, data_q, a_q, b_q, aluout;
    logic [W-1:0] adr_q, wdata_q;
    logic         we_q;

    logic [W-1:0] rd1, rd2, srca, srcb, signimm, aluresult, pc_next, wd;
    logic [W:0]   sum;
    logic         carry, zero, cond_ok, rf_we;
    logic [2:0]   wsel;
    logic [RA-1:0] wa;

    // ---------------- memory handshake FSM ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= M_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            M_IDLE:  if (memstart) state_n = M_BUSY;
            M_BUSY:  if (mem_ack)  state_n = M_DONE;
            M_DONE:  state_n = M_IDLE;
            default: state_n = M_IDLE;
        endcase
    end

    assign busy      = (state == M_BUSY);
    assign memdone   = (state == M_DONE);
    assign mem_req   = busy;
    assign mem_we    = busy & we_q;
    assign mem_adr   = adr_q;
    assign mem_wdata = wdata_q;

    // ---------------- operand selection and ALU ----------------
    assign signimm = pcsrc[1] ? {{(W-IMMJ){instr[IMMJ-1]}}, instr[IMMJ-1:0]}
                              : {{(W-IMMB){instr[IMMB-1]}}, instr[IMMB-1:0]};
    assign srca = alusrca ? a_q : pc;

    always_comb begin
        case (alusrcb)
            2'b00:   srcb = b_q;
            2'b01:   srcb = {{(W-2){1'b0}}, 2'b10};
            2'b10:   srcb = signimm;
            default: srcb = {signimm[W-2:0], 1'b0};
        endcase
    end

    always_comb begin
        sum       = '0;
        carry     = 1'b0;
        aluresult = '0;
        case (alu_op_e'(alucontrol))
            ALU_ADD: begin
                sum       = {1'b0, srca} + {1'b0, srcb};
                aluresult = sum[W-1:0];
                carry     = sum[W];
            end
            ALU_SUB: begin
                // carry out of a + ~b + 1 is set when no borrow occurs
                sum       = {1'b0, srca} + {1'b0, ~srcb} + {{W{1'b0}}, 1'b1};
                aluresult = sum[W-1:0];
                carry     = sum[W];
            end
            ALU_NAND: aluresult = ~(srca & srcb);
            ALU_AND:  aluresult = srca & srcb;
            ALU_OR:   aluresult = srca | srcb;
            ALU_XOR:  aluresult = srca ^ srcb;
            ALU_SHL:  aluresult = {srca[W-2:0], 1'b0};
            default:  aluresult = srcb;
        endcase
    end

    assign zero    = (aluresult == '0);
    assign compare = (srca == srcb);
    assign op      = instr[15:12];

    // ---------------- register file write path ----------------
    always_comb begin
        case (cond_e'(instr[1:0]))
            COND_Z:  cond_ok = zflag;
            COND_C:  cond_ok = cflag;
            default: cond_ok = 1'b1;
        endcase
    end

    // Jumps write the link value to the top register unconditionally.
    assign rf_we = regwrite & ~busy & (pcsrc[1] | cond_ok);
    assign wsel  = regdst ? instr[5:3] : instr[8:6];
    assign wa    = pcsrc[1] ? RA'(NREG-1) : RA'(wsel);
    assign wd    = pcsrc[1] ? aluresult : (memtoreg ? data_q : aluout);

    regfile_p #(.W(W), .NREG(NREG), .RA(RA)) u_rf (
        .clk  (clk),
        .reset(reset),
        .we   (rf_we),
        .wa   (wa),
        .wd   (wd),
        .ra1  (RA'(instr[11:9])),
        .ra2  (RA'(instr[8:6])),
        .rd1  (rd1),
        .rd2  (rd2),
        .regs (regs)
    );

    always_comb begin
        case (pcsrc_e'(pcsrc))
            PC_ALU:  pc_next = aluresult;
            PC_JR:   pc_next = a_q;
            default: pc_next = aluout;
        endcase
    end

    // ---------------- architectural and pipeline registers ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc      <= RESET_PC;
            instr   <= '0;
            data_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            aluout  <= '0;
            cflag   <= 1'b0;
            zflag   <= 1'b0;
            adr_q   <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
        end else begin
            if (state == M_IDLE && memstart) begin
                adr_q   <= iord ? aluout : pc;
                we_q    <= memwe;
                wdata_q <= b_q;
            end
            if (state == M_BUSY && mem_ack) begin
                data_q <= mem_rdata;
                if (irwrite) instr <= mem_rdata;
            end
            if (!busy) begin
                a_q    <= rd1;
                b_q    <= rd2;
                aluout <= aluresult;
                if (flagwrite) begin
                    cflag <= carry;
                    zflag <= zero;
                end
                if (pcen) pc <= pc_next;
            end
        end
    end

endmodule

// File: tb/tb_mcdatapath_p.sv
// Directed bench for mcdatapath_p: default 16-bit build plus a 32-bit/16-reg
// build used for the reset-during-access case.
module tb_mcdatapath_p;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, reset2;
    logic pcen, irwrite, regwrite, flagwrite, alusrca, iord, memtoreg, regdst;
    logic memstart, memwe, memstart2;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;

    logic [3:0]   op, op2;
    logic         compare, busy, memdone, mem_req, mem_we, cflag, zflag;
    logic         compare2, busy2, memdone2, mem_req2, mem_we2, cflag2, zflag2;
    logic [15:0]  mem_adr, mem_wdata, mem_rdata, pc;
    logic [31:0]  mem_adr2, mem_wdata2, mem_rdata2, pc2;
    logic         mem_ack, mem_ack2;
    logic [127:0] regs;
    logic [511:0] regs2;

    int total = 0;
    int bad   = 0;
    int nr, nd, n;
    logic [15:0] a0, a1, d0;
    logic        w0;

    mcdatapath_p dut (
        .clk(clk), .reset(reset), .pcen(pcen), .irwrite(irwrite), .regwrite(regwrite),
        .flagwrite(flagwrite), .alusrca(alusrca), .iord(iord), .memtoreg(memtoreg),
        .regdst(regdst), .memstart(memstart), .memwe(memwe), .alusrcb(alusrcb),
        .pcsrc(pcsrc), .alucontrol(alucontrol), .op(op), .compare(compare), .busy(busy),
        .memdone(memdone), .mem_req(mem_req), .mem_we(mem_we), .mem_adr(mem_adr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .pc(pc),
        .cflag(cflag), .zflag(zflag), .regs(regs)
    );

    mcdatapath_p #(.W(32), .NREG(16)) dut2 (
        .clk(clk), .reset(reset2), .pcen(pcen), .irwrite(irwrite), .regwrite(regwrite),
        .flagwrite(flagwrite), .alusrca(alusrca), .iord(iord), .memtoreg(memtoreg),
        .regdst(regdst), .memstart(memstart2), .memwe(memwe), .alusrcb(alusrcb),
        .pcsrc(pcsrc), .alucontrol(alucontrol), .op(op2), .compare(compare2), .busy(busy2),
        .memdone(memdone2), .mem_req(mem_req2), .mem_we(mem_we2), .mem_adr(mem_adr2),
        .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2), .mem_ack(mem_ack2), .pc(pc2),
        .cflag(cflag2), .zflag(zflag2), .regs(regs2)
    );

    function automatic logic [15:0] r(input int i);
        return regs[i*16 +: 16];
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task tick();
        @(posedge clk);
        #1;
    endtask

    // One access: ack on the nbusy-th BUSY cycle; iord is flipped mid-access
    // so a non-frozen address shows up in a1.
    task automatic mem_op(input logic [15:0] rd, input int nbusy,
                          output int nreq, output int ndone,
                          output logic [15:0] adr0, output logic [15:0] adr1,
                          output logic we0, output logic [15:0] wd0);
        nreq = 0; ndone = 0; adr1 = '0;
        memstart = 1'b1;
        tick();
        memstart = 1'b0;
        adr0 = mem_adr; we0 = mem_we; wd0 = mem_wdata;
        iord = ~iord;
        for (int i = 0; i < nbusy + 3; i++) begin
            if (mem_req) nreq++;
            if (memdone) ndone++;
            if (i == nbusy - 1) adr1 = mem_adr;
            mem_ack   = (i == nbusy - 1);
            mem_rdata = rd;
            tick();
        end
        mem_ack = 1'b0;
        iord = ~iord;
    endtask

    logic [2:0]  alu_op_t  [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    logic [15:0] alu_res_t [8] = '{16'h0000, 16'hFFFE, 16'hFFFE, 16'h0001,
                                   16'hFFFF, 16'hFFFE, 16'hFFFE, 16'h0001};
    logic        alu_c_t   [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic        alu_z_t   [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    initial begin
        reset = 0; reset2 = 0;
        {pcen, irwrite, regwrite, flagwrite, alusrca, iord, memtoreg, regdst} = '0;
        memstart = 0; memwe = 0; memstart2 = 0;
        alusrcb = 2'b00; pcsrc = 2'b00; alucontrol = 3'b000;
        mem_rdata = '0; mem_ack = 0; mem_rdata2 = '0; mem_ack2 = 0;

        tick(); tick();
        chk("rst_pc", pc, 16'h0000);
        chk("rst_req", mem_req, 0);
        chk("rst_busy", busy, 0);
        reset = 1;
        tick();
        chk("rel_regs0", regs == '0, 1);
        chk("rel_pc", pc, 16'h0000);
        chk("rel_flags", {cflag, zflag, memdone, mem_req, busy}, 5'b0);

        // idle ALU setting: pass constant 2, so aluout = 2
        alucontrol = 3'b111; alusrcb = 2'b01;
        tick();

        // fetch with three wait cycles
        irwrite = 1;
        mem_op(16'h1234, 3, nr, nd, a0, a1, w0, d0);
        chk("fetch_req_cyc", nr, 3);
        chk("fetch_done_pulse", nd, 1);
        chk("fetch_op", op, 4'h1);
        chk("fetch_adr", a0, 16'h0000);
        chk("fetch_adr_frozen", a1, 16'h0000);
        chk("fetch_pc_hold", pc, 16'h0000);

        // step pc by 2 up to 0x10
        pcen = 1; alucontrol = 3'b000;
        tick();
        chk("pc_step", pc, 16'h0002);
        repeat (7) tick();
        pcen = 0; alucontrol = 3'b111;
        chk("pc_0x10", pc, 16'h0010);
        tick();

        // instr 0x2288: ra1=r1, ra2=r2, wa(regdst)=r1, wa(!regdst)=r2, cond 00
        mem_op(16'h2288, 1, nr, nd, a0, a1, w0, d0);
        chk("op_2288", op, 4'h2);
        irwrite = 0;
        mem_op(16'hFFFF, 1, nr, nd, a0, a1, w0, d0);
        regwrite = 1; memtoreg = 1; regdst = 1;
        tick();
        regwrite = 0;
        chk("r1_load", r(1), 16'hFFFF);
        mem_op(16'h0001, 1, nr, nd, a0, a1, w0, d0);
        regwrite = 1; memtoreg = 1; regdst = 0;
        tick();
        regwrite = 0; memtoreg = 0;
        chk("r2_load", r(2), 16'h0001);
        tick();

        alusrca = 1; alusrcb = 2'b00; #1;
        chk("cmp_ne", compare, 0);
        alusrca = 0; alusrcb = 2'b11; #1;
        chk("cmp_eq", compare, 1);

        // ALU table on A=0xFFFF, B=0x0001, results land in r7 via link path
        alusrca = 1; alusrcb = 2'b00; pcsrc = 2'b10; regwrite = 1; flagwrite = 1;
        for (int i = 0; i < 8; i++) begin
            alucontrol = alu_op_t[i];
            tick();
            chk($sformatf("alu%0d_res", i), r(7), alu_res_t[i]);
            chk($sformatf("alu%0d_c", i), cflag, alu_c_t[i]);
            chk($sformatf("alu%0d_z", i), zflag, alu_z_t[i]);
        end
        alucontrol = 3'b000;
        tick();
        regwrite = 0; flagwrite = 0; pcsrc = 2'b00;
        alusrca = 0; alusrcb = 2'b01; alucontrol = 3'b111;
        chk("add_c_z", {cflag, zflag}, 2'b11);
        tick();

        // data write at aluout address, B as write data
        memwe = 1; iord = 1;
        mem_op(16'h0000, 2, nr, nd, a0, a1, w0, d0);
        memwe = 0; iord = 0;
        chk("wr_adr", a0, 16'h0002);
        chk("wr_adr_frozen", a1, 16'h0002);
        chk("wr_we", w0, 1);
        chk("wr_data", d0, 16'h0001);
        chk("wr_we_idle", mem_we, 0);

        // conditional writes
        irwrite = 1;
        mem_op(16'h228A, 1, nr, nd, a0, a1, w0, d0);
        irwrite = 0;
        regwrite = 1; regdst = 1;
        tick();
        regwrite = 0;
        chk("cond_c_write", r(1), 16'h0002);
        flagwrite = 1;
        tick();
        flagwrite = 0;
        chk("flags_clr", {cflag, zflag}, 2'b00);
        irwrite = 1;
        mem_op(16'h2289, 1, nr, nd, a0, a1, w0, d0);
        irwrite = 0; alusrcb = 2'b10;
        tick();
        regwrite = 1;
        tick();
        regwrite = 0; regdst = 0; alusrcb = 2'b01;
        chk("cond_z_nowrite", r(1), 16'h0002);

        // jump with link: imm9 = 0x1FF
        chk("pc_pre_jmp", pc, 16'h0010);
        irwrite = 1;
        mem_op(16'h21FF, 1, nr, nd, a0, a1, w0, d0);
        irwrite = 0;
        pcsrc = 2'b10; alucontrol = 3'b000; alusrcb = 2'b11;
        tick();
        alusrcb = 2'b01; pcen = 1; regwrite = 1;
        tick();
        pcen = 0; regwrite = 0; pcsrc = 2'b00;
        chk("jmp_pc", pc, 16'h000E);
        chk("jmp_link", r(7), 16'h0012);

        // memstart and pcen held during BUSY
        memstart = 1;
        tick();
        pcen = 1; n = 0;
        for (int i = 0; i < 3; i++) begin
            if (mem_req) n++;
            mem_ack = (i == 2);
            tick();
        end
        mem_ack = 0; pcen = 0;
        chk("hold_done", memdone, 1);
        tick();
        memstart = 0;
        chk("hold_no_restart", mem_req, 0);
        tick();
        chk("hold_idle", {mem_req, busy}, 2'b00);
        chk("hold_req_cyc", n, 3);
        chk("hold_pc", pc, 16'h000E);

        // jump-register: instr[11:9]=0 selects r0
        pcsrc = 2'b11; pcen = 1;
        tick();
        pcen = 0; pcsrc = 2'b00;
        chk("jr_pc", pc, 16'h0000);

        // wide build: reset in the middle of an access
        irwrite = 1; alucontrol = 3'b000; alusrcb = 2'b00;
        reset2 = 1;
        tick();
        memstart2 = 1;
        tick();
        memstart2 = 0;
        chk("w32_busy", {busy2, mem_req2}, 2'b11);
        tick();
        #4 reset2 = 0;
        #1;
        chk("w32_abort_req", mem_req2, 0);
        chk("w32_abort_busy", busy2, 0);
        mem_ack2 = 1; mem_rdata2 = 32'hDEADBEEF;
        tick();
        reset2 = 1;
        tick();
        chk("w32_late_ack", {busy2, memdone2}, 2'b00);
        chk("w32_op", op2, 4'h0);
        mem_ack2 = 0; irwrite = 0;
        regwrite = 1; memtoreg = 1;
        tick();
        regwrite = 0; memtoreg = 0;
        chk("w32_r0", regs2[31:0], 32'h0);
        chk("w32_r3", regs2[3*32 +: 32], 32'h0);
        chk("w32_pc", pc2, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
